// File: rtl/c2h_patgen_pkg.sv
// +----------------------------------------------------------------------+
// | c2h_patgen_pkg : shared constants, state encoding and LFSR step      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package c2h_patgen_pkg;

  localparam logic [1:0] PAT_BYTE = 2'd0;
  localparam logic [1:0] PAT_WORD = 2'd1;
  localparam logic [1:0] PAT_LFSR = 2'd2;
  localparam logic [1:0] PAT_FILL = 2'd3;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Right-shifting Galois form: bit i of the mask is the x^(i+1) tap.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/patgen_lfsr32.sv
// +----------------------------------------------------------------------+
// | patgen_lfsr32 : 32-bit Galois LFSR with seed load and advance enable |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module patgen_lfsr32
  import c2h_patgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LFSR_SEED;
    end else if (i_load) begin
      r_state <= LFSR_SEED;
    end else if (i_adv) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/c2h_pattern_gen.sv
// +----------------------------------------------------------------------+
// | c2h_pattern_gen : packetised AXI-stream test-data source for C2H DMA |
// | Optional error injector: define C2H_PATGEN_ERRINJ_EN                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module c2h_pattern_gen
  import c2h_patgen_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 256,
  parameter int PKT_CNT_W = 16
) (
  input  logic                 clk_50m,
  input  logic                 usr_rst,
  input  logic                 run_i,
  input  logic                 chan_rst_i,
  input  logic [1:0]           mode_i,
  input  logic [7:0]           fill_i,
  input  logic [PKT_CNT_W-1:0] pkt_cnt_i,
`ifdef C2H_PATGEN_ERRINJ_EN
  input  logic                 err_inj_i,
`endif
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PKT_CNT_W-1:0] pkts_sent_o
);

  localparam int c_NB     = DATA_W / 8;
  localparam int c_NW     = DATA_W / 32;
  localparam int c_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [7:0]            r_fill;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;
  logic [PKT_CNT_W-1:0]  r_pkts_sent;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [7:0]            r_byte_base;
  logic [31:0]           r_word_base;
  logic [DATA_W-1:0]     r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_start;
  logic                  w_cont;
  logic                  w_cnt_hit;
  logic [PKT_CNT_W-1:0]  w_pkts_nxt;
  logic [c_BEAT_W-1:0]   w_beat_nxt;
  logic                  w_tlast_nxt;
  logic [7:0]            w_byte_nxt;
  logic [31:0]           w_word_nxt;
  logic [31:0]           w_lfsr;
  logic [DATA_W-1:0]     w_pat_nxt;
  logic [DATA_W-1:0]     w_pat_start;
  logic                  w_inj;
  logic [DATA_W-1:0]     w_inj_mask;

  // Byte lanes carry the byte-ramp/fill patterns, 32-bit lanes the word/LFSR ones.
  function automatic logic [DATA_W-1:0] f_pat(
    input logic [1:0]  mode,
    input logic [7:0]  fill,
    input logic [7:0]  byte_base,
    input logic [31:0] word_base,
    input logic [31:0] lfsr
  );
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < c_NB; k++) begin
      d[8*k +: 8] = (mode == PAT_FILL) ? fill : byte_base + 8'(k);
    end
    for (int j = 0; j < c_NW; j++) begin
      case (mode)
        PAT_WORD: d[32*j +: 32] = word_base + 32'(j);
        PAT_LFSR: d[32*j +: 32] = lfsr ^ {4{8'(j)}};
        default:  ;
      endcase
    end
    return d;
  endfunction

  assign w_accept    = r_tvalid & m_axis_tready;
  assign w_pkts_nxt  = r_pkts_sent + 1'b1;
  assign w_cnt_hit   = (r_pkt_cnt != '0) && (w_pkts_nxt == r_pkt_cnt);
  assign w_start     = (r_state == ST_IDLE) && run_i;
  // A new beat is loaded unless the accepted beat ends the whole run.
  assign w_cont      = w_accept && (!r_tlast ||
                       (!w_cnt_hit && run_i && (r_state == ST_RUN)));
  assign w_beat_nxt  = r_tlast ? '0 : r_beat + 1'b1;
  assign w_tlast_nxt = (w_beat_nxt == c_LAST_BEAT);
  assign w_byte_nxt  = r_byte_base + 8'(c_NB);
  assign w_word_nxt  = r_word_base + 32'(c_NW);
  assign w_pat_nxt   = f_pat(r_mode, r_fill, w_byte_nxt, w_word_nxt, lfsr_step(w_lfsr));
  assign w_pat_start = f_pat(mode_i, fill_i, 8'd0, 32'd0, LFSR_SEED);
  assign w_inj_mask  = {{(DATA_W-1){1'b0}}, w_inj};

`ifdef C2H_PATGEN_ERRINJ_EN
  logic r_inj_pend;

  assign w_inj = r_inj_pend | err_inj_i;

  always_ff @(posedge clk_50m) begin
    if (usr_rst || chan_rst_i) begin
      r_inj_pend <= 1'b0;
    end else if (w_start || w_cont) begin
      r_inj_pend <= 1'b0;
    end else if (err_inj_i) begin
      r_inj_pend <= 1'b1;
    end
  end
`else
  assign w_inj = 1'b0;
`endif

  patgen_lfsr32 u_lfsr (
    .clk     (clk_50m),
    .rst     (usr_rst),
    .i_load  (chan_rst_i | w_start),
    .i_adv   (w_accept),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk_50m) begin
    if (usr_rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= PAT_BYTE;
      r_fill      <= 8'd0;
      r_pkt_cnt   <= '0;
      r_pkts_sent <= '0;
      r_beat      <= '0;
      r_byte_base <= 8'd0;
      r_word_base <= 32'd0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
    end else if (chan_rst_i) begin
      // Abort: pkts_sent keeps its value so software can read how far it got.
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_byte_base <= 8'd0;
      r_word_base <= 32'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run_i) begin
            r_state     <= ST_RUN;
            r_mode      <= mode_i;
            r_fill      <= fill_i;
            r_pkt_cnt   <= pkt_cnt_i;
            r_pkts_sent <= '0;
            r_beat      <= '0;
            r_byte_base <= 8'd0;
            r_word_base <= 32'd0;
            r_tdata     <= w_pat_start ^ w_inj_mask;
            r_tvalid    <= 1'b1;
            r_tlast     <= (c_LAST_BEAT == '0);
          end
        end
        ST_RUN, ST_STOP: begin
          if (w_accept) begin
            r_beat      <= w_beat_nxt;
            r_byte_base <= w_byte_nxt;
            r_word_base <= w_word_nxt;
            if (r_tlast) begin
              r_pkts_sent <= w_pkts_nxt;
            end
          end
          if (w_cont) begin
            r_tdata <= w_pat_nxt ^ w_inj_mask;
            r_tlast <= w_tlast_nxt;
            if (!run_i) begin
              r_state <= ST_STOP;
            end
          end else if (w_accept) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (w_cnt_hit) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!run_i) begin
            r_state <= ST_STOP;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = r_done;
  assign pkts_sent_o   = r_pkts_sent;

endmodule

`default_nettype wire

// File: tb/tb_c2h_pattern_gen.sv
// +----------------------------------------------------------------------+
// | tb_c2h_pattern_gen : self-checking bench for c2h_pattern_gen         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_c2h_pattern_gen;

  localparam int DW = 64;
  localparam int BL = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          usr_rst;
  logic          run_i;
  logic          chan_rst_i;
  logic [1:0]    mode;
  logic [7:0]    fill;
  logic [PW-1:0] pkt_cnt;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          busy;
  logic          done;
  logic [PW-1:0] pkts;
`ifdef C2H_PATGEN_ERRINJ_EN
  logic          err_inj;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] lfsr_ref [0:255];

  always #5 clk = ~clk;

  c2h_pattern_gen #(.DATA_W(DW), .BURST_LEN(BL), .PKT_CNT_W(PW)) dut (
    .clk_50m       (clk),
    .usr_rst       (usr_rst),
    .run_i         (run_i),
    .chan_rst_i    (chan_rst_i),
    .mode_i        (mode),
    .fill_i        (fill),
    .pkt_cnt_i     (pkt_cnt),
`ifdef C2H_PATGEN_ERRINJ_EN
    .err_inj_i     (err_inj),
`endif
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy_o        (busy),
    .done_o        (done),
    .pkts_sent_o   (pkts)
  );

  // Reference: beat n of a run, computed straight from the pattern rules.
  function automatic logic [DW-1:0] exp_data(input int m, input logic [7:0] f, input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < DW/8; k++) begin
      if (m == 0) d[8*k +: 8] = 8'((n*(DW/8) + k) % 256);
      if (m == 3) d[8*k +: 8] = f;
    end
    for (int j = 0; j < DW/32; j++) begin
      if (m == 1) d[32*j +: 32] = 32'(n*(DW/32) + j);
      if (m == 2) d[32*j +: 32] = lfsr_ref[n] ^ {4{8'(j)}};
    end
    return d;
  endfunction

  task automatic quiesce();
    run_i      = 1'b0;
    chan_rst_i = 1'b1;
    @(posedge clk); #1;
    chan_rst_i = 1'b0;
    tready     = 1'b1;
  endtask

  task automatic test_reset();
    usr_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || pkts !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b last=%b data=%h busy=%b done=%b pkts=%0d, want all zero",
               tvalid, tlast, tdata, busy, done, pkts);
    end
    usr_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_ramp();
    int n = 0;
    int dones = 0;
    logic [DW-1:0] b0 = '0;
    logic [DW-1:0] b3 = '0;
    logic [DW-1:0] exp0 = 64'h0706050403020100;
    logic [DW-1:0] exp3 = 64'h1F1E1D1C1B1A1918;
    mode = 2'd0; fill = 8'd0; pkt_cnt = 16'd2; tready = 1'b1; run_i = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (done) begin dones++; run_i = 1'b0; end
      if (tvalid && tready) begin
        checks++;
        if (tdata !== exp_data(0, 8'd0, n) || tlast !== (n % BL == BL-1)) begin
          errors++;
          $display("FAIL byte_ramp beat %0d: got data=%h last=%b, want data=%h last=%b",
                   n, tdata, tlast, exp_data(0, 8'd0, n), (n % BL == BL-1));
        end
        if (n == 0) b0 = tdata;
        if (n == 3) b3 = tdata;
        n++;
      end
    end
    checks++;
    if (b0 !== exp0 || b3 !== exp3) begin
      errors++;
      $display("FAIL byte_ramp_beats03: got %h / %h, want %h / %h", b0, b3, exp0, exp3);
    end
    checks++;
    if (n != 8 || dones != 1 || pkts !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL byte_ramp_end: got beats=%0d dones=%0d pkts=%0d busy=%b, want 8 1 2 0",
               n, dones, pkts, busy);
    end
    quiesce();
  endtask

  task automatic test_byte_wrap();
    int n = 0;
    logic [DW-1:0] b32 = '0;
    logic [DW-1:0] exp32 = 64'h0706050403020100;
    mode = 2'd0; pkt_cnt = 16'd0; tready = 1'b1; run_i = 1'b1;
    for (int cyc = 0; cyc < 60 && (n < 36); cyc++) begin
      @(posedge clk); #1;
      if (tvalid && tready) begin
        checks++;
        if (tdata !== exp_data(0, 8'd0, n) || tlast !== (n % BL == BL-1)) begin
          errors++;
          $display("FAIL byte_wrap beat %0d: got data=%h last=%b, want data=%h last=%b",
                   n, tdata, tlast, exp_data(0, 8'd0, n), (n % BL == BL-1));
        end
        if (n == 32) begin b32 = tdata; run_i = 1'b0; end
        n++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (b32 !== exp32 || n != 36 || busy !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL byte_wrap_end: got beat32=%h beats=%0d busy=%b valid=%b, want %h 36 0 0",
               b32, n, busy, tvalid, exp32);
    end
    quiesce();
  endtask

  task automatic test_lfsr_backpressure();
    int n = 0;
    int dones = 0;
    logic prev_stall = 1'b0;
    logic prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    mode = 2'd2; pkt_cnt = 16'd5; tready = 1'b0; run_i = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (done) begin dones++; run_i = 1'b0; end
      if (prev_stall) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
          errors++;
          $display("FAIL lfsr_stall_hold: got valid=%b data=%h last=%b, want 1 %h %b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      tready = 1'($urandom % 2);
      if (tvalid && tready) begin
        checks++;
        if (tdata !== exp_data(2, 8'd0, n) || tlast !== (n % BL == BL-1)) begin
          errors++;
          $display("FAIL lfsr beat %0d: got data=%h last=%b, want data=%h last=%b",
                   n, tdata, tlast, exp_data(2, 8'd0, n), (n % BL == BL-1));
        end
        n++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
    checks++;
    if (n != 20 || dones != 1 || pkts !== 16'd5) begin
      errors++;
      $display("FAIL lfsr_end: got beats=%0d dones=%0d pkts=%0d, want 20 1 5", n, dones, pkts);
    end
    quiesce();
  endtask

  task automatic test_graceful_stop();
    int n = 0;
    int dones = 0;
    mode = 2'd1; pkt_cnt = 16'd0; tready = 1'b1; run_i = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (tvalid && tready) begin
        checks++;
        if (tdata !== exp_data(1, 8'd0, n) || tlast !== (n % BL == BL-1)) begin
          errors++;
          $display("FAIL stop beat %0d: got data=%h last=%b, want data=%h last=%b",
                   n, tdata, tlast, exp_data(1, 8'd0, n), (n % BL == BL-1));
        end
        if (n == 1) run_i = 1'b0;
        n++;
      end
    end
    checks++;
    if (n != 4 || dones != 0 || busy !== 1'b0 || tvalid !== 1'b0 || pkts !== 16'd1) begin
      errors++;
      $display("FAIL stop_end: got beats=%0d dones=%0d busy=%b valid=%b pkts=%0d, want 4 0 0 0 1",
               n, dones, busy, tvalid, pkts);
    end
    quiesce();
  endtask

  task automatic test_abort();
    int n = 0;
    logic [DW-1:0] exp_w = {32'd1, 32'd0};
    mode = 2'd0; pkt_cnt = 16'd0; tready = 1'b1; run_i = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 6; cyc++) begin
      @(posedge clk); #1;
      if (tvalid && tready) begin
        checks++;
        if (tdata !== exp_data(0, 8'd0, n)) begin
          errors++;
          $display("FAIL abort_pre beat %0d: got %h, want %h", n, tdata, exp_data(0, 8'd0, n));
        end
        n++;
      end
    end
    run_i = 1'b0; chan_rst_i = 1'b1;
    @(posedge clk); #1;
    chan_rst_i = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || pkts !== 16'd1) begin
      errors++;
      $display("FAIL abort: got valid=%b last=%b busy=%b pkts=%0d, want 0 0 0 1",
               tvalid, tlast, busy, pkts);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pkts !== 16'd1 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: got pkts=%0d valid=%b, want 1 0", pkts, tvalid);
    end
    mode = 2'd1; run_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tvalid !== 1'b1 || tdata !== exp_w || pkts !== 16'd0) begin
      errors++;
      $display("FAIL abort_restart: got valid=%b data=%h pkts=%0d, want 1 %h 0",
               tvalid, tdata, pkts, exp_w);
    end
    quiesce();
  endtask

`ifdef C2H_PATGEN_ERRINJ_EN
  task automatic test_errinj();
    int n = 0;
    int hits = 0;
    int bad = 0;
    logic [DW-1:0] good = {8{8'hA5}};
    logic [DW-1:0] hit  = {{7{8'hA5}}, 8'hA4};
    mode = 2'd3; fill = 8'hA5; pkt_cnt = 16'd0; tready = 1'b1; run_i = 1'b1; err_inj = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      err_inj = 1'b0;
      if (tvalid && tready) begin
        if (tdata === hit) hits++;
        else if (tdata !== good) bad++;
        if (n == 3) err_inj = 1'b1;
        n++;
      end
    end
    checks++;
    if (hits != 1 || bad != 0) begin
      errors++;
      $display("FAIL errinj: got injected=%0d other_bad=%0d, want 1 0", hits, bad);
    end
    quiesce();
  endtask
`endif

  initial begin
    lfsr_ref[0] = 32'hFFFFFFFF;
    for (int i = 1; i < 256; i++) begin
      lfsr_ref[i] = (lfsr_ref[i-1] >> 1) ^ (lfsr_ref[i-1][0] ? 32'h80200003 : 32'h0);
    end
    usr_rst = 1'b1; run_i = 1'b0; chan_rst_i = 1'b0; mode = 2'd0; fill = 8'd0;
    pkt_cnt = '0; tready = 1'b1;
`ifdef C2H_PATGEN_ERRINJ_EN
    err_inj = 1'b0;
`endif
    test_reset();
    test_byte_ramp();
    test_byte_wrap();
    test_lfsr_backpressure();
    test_graceful_stop();
    test_abort();
`ifdef C2H_PATGEN_ERRINJ_EN
    test_errinj();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
